divmod: RTL and testbench

//  Iterative unsigned/signed integer divider returning quotient and remainder.

---
 rtl/divmod_pkg.sv | 11 +
 rtl/divmod_msb_index.sv | 18 +
 rtl/divmod.sv | 123 ++++++++++++
 tb/tb_divmod.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/divmod_pkg.sv
// Shared types and defaults for the iterative divider.
package divmod_pkg;

  localparam int DM_WIDTH_DEF = 16;

  typedef enum logic {
    DM_IDLE = 1'b0,
    DM_RUN  = 1'b1
  } dm_state_e;

endpackage

// File: rtl/divmod_msb_index.sv
// Priority encoder returning the index of the highest set bit (0 for input 0).
module divmod_msb_index #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         val_i,
  output logic [$clog2(WIDTH)-1:0] idx_o
);

  localparam int SW = $clog2(WIDTH);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (val_i[i]) idx_o = i[SW-1:0];
    end
  end

endmodule

// File: rtl/divmod.sv
// Iterative restoring divider, signed or unsigned per operation, one quotient
// bit per clock; reports quotient, remainder, divide-by-zero and a done pulse.
module divmod
  import divmod_pkg::*;
#(
  parameter int WIDTH = DM_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             go_i,
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic             error_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int SW = $clog2(WIDTH);

  dm_state_e        state_q;
  logic             go_prev_q;
  logic             ready_q, done_q, err_q;
  logic [WIDTH-1:0] quo_q, rem_q;
  logic [WIDTH-1:0] a_q, b_q, q_q;
  logic [SW-1:0]    s_q;
  logic             negq_q, nega_q;

  logic             start;
  logic [WIDTH-1:0] abs_a, abs_b, b_init;
  logic [SW-1:0]    msb_a, msb_b, s_init;
  logic             fits, last;
  logic [WIDTH-1:0] a_d, q_d, quo_fin, rem_fin;

  assign start = go_i & ~go_prev_q;
  assign abs_a = (sgn_i & a_i[WIDTH-1]) ? -a_i : a_i;
  assign abs_b = (sgn_i & b_i[WIDTH-1]) ? -b_i : b_i;

  divmod_msb_index #(.WIDTH(WIDTH)) u_msb_a (.val_i(abs_a), .idx_o(msb_a));
  divmod_msb_index #(.WIDTH(WIDTH)) u_msb_b (.val_i(abs_b), .idx_o(msb_b));

  // Align divisor's top bit under the dividend's so no leading zero steps run.
  assign s_init = (msb_a > msb_b) ? (msb_a - msb_b) : '0;
  assign b_init = abs_b << s_init;

  assign fits = (b_q <= a_q);
  assign last = (s_q == '0);

  always_comb begin
    a_d = fits ? (a_q - b_q) : a_q;
    q_d = q_q;
    if (fits) q_d[s_q] = 1'b1;
    quo_fin = negq_q ? -q_d : q_d;
    rem_fin = nega_q ? -a_d : a_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= DM_IDLE;
      go_prev_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      q_q       <= '0;
      s_q       <= '0;
      negq_q    <= 1'b0;
      nega_q    <= 1'b0;
    end else begin
      go_prev_q <= go_i;
      done_q    <= 1'b0;
      // A start edge always wins, which also aborts an operation in flight.
      if (start) begin
        if (b_i == '0) begin
          state_q <= DM_IDLE;
          quo_q   <= '1;
          rem_q   <= a_i;
          err_q   <= 1'b1;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
        end else begin
          a_q     <= abs_a;
          b_q     <= b_init;
          q_q     <= '0;
          s_q     <= s_init;
          negq_q  <= sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          nega_q  <= sgn_i & a_i[WIDTH-1];
          state_q <= DM_RUN;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
      end else if (state_q == DM_RUN) begin
        a_q <= a_d;
        q_q <= q_d;
        if (last) begin
          quo_q   <= quo_fin;
          rem_q   <= rem_fin;
          state_q <= DM_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
        end else begin
          b_q <= b_q >> 1;
          s_q <= s_q - 1'b1;
        end
      end
    end
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign error_o = err_q;
  assign quo_o   = quo_q;
  assign rem_o   = rem_q;

  a_done_idle: assert property (@(posedge clk_i) disable iff (rst_i) done_q |-> ready_q);
  a_ready_st:  assert property (@(posedge clk_i) disable iff (rst_i) ready_q == (state_q == DM_IDLE));

endmodule

// File: tb/tb_divmod.sv
// Self-checking bench for divmod: fixed vectors, corner sequences, random ops.
module tb_divmod;

  logic        clk = 1'b0;
  logic        rst, go, sgn;
  logic [15:0] a_in, b_in;
  logic        ready_o, done_o, error_o;
  logic [15:0] quo_o, rem_o;

  int checks = 0;
  int errors = 0;

  divmod #(.WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .go_i(go), .sgn_i(sgn), .a_i(a_in), .b_i(b_in),
    .ready_o(ready_o), .done_o(done_o), .error_o(error_o), .quo_o(quo_o), .rem_o(rem_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [15:0] a, b, q, r;
    logic        e;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int msb_of(input int v);
    int m = 0;
    for (int i = 0; i < 32; i++) if (v >= (1 << i) && i < 31) m = i;
    return m;
  endfunction

  // Reference: plain integer division; latency from the bit-alignment distance.
  function automatic void ref_model(input logic s, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output logic e, output int lat);
    int sa, sb, ma, mb, d;
    if (b == 16'd0) begin
      q = 16'hFFFF; r = a; e = 1'b1; lat = 1;
      return;
    end
    e = 1'b0;
    if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q = 16'(sa / sb);
      r = 16'(sa % sb);
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
    end else begin
      q = a / b;
      r = a % b;
      ma = int'(a);
      mb = int'(b);
    end
    d = msb_of(ma) - msb_of(mb);
    lat = 2 + ((d > 0) ? d : 0);
  endfunction

  task automatic do_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                       output int edges, output logic hold_ok);
    logic [15:0] q0, r0;
    @(negedge clk);
    q0 = quo_o; r0 = rem_o;
    sgn = s; a_in = a; b_in = b; go = 1'b1;
    hold_ok = 1'b1; edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (!done_o && (ready_o || quo_o !== q0 || rem_o !== r0)) hold_ok = 1'b0;
    end while (!done_o && edges < 40);
    go = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", done_o, 1'b0);
  endtask

  vec_t vecs[9];
  int   edges, nd;
  logic hold_ok;
  logic [15:0] eq, er;
  logic        ee;
  int          el;

  initial begin
    vecs[0] = '{1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 6};
    vecs[1] = '{1'b0, 16'd5,    16'd9,    16'd0,    16'd5,    1'b0, 2};
    vecs[2] = '{1'b0, 16'd0,    16'd1,    16'd0,    16'd0,    1'b0, 2};
    vecs[3] = '{1'b1, 16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0, 3};
    vecs[4] = '{1'b1, 16'd7,    16'hFFFE, 16'hFFFD, 16'd1,    1'b0, 3};
    vecs[5] = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0, 17};
    vecs[6] = '{1'b0, 16'd42,   16'd0,    16'hFFFF, 16'd42,   1'b1, 1};
    vecs[7] = '{1'b0, 16'hFFFF, 16'd1,    16'hFFFF, 16'd0,    1'b0, 17};
    vecs[8] = '{1'b1, 16'hFFFF, 16'd0,    16'hFFFF, 16'hFFFF, 1'b1, 1};

    rst = 1'b1; go = 1'b0; sgn = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready_o, 1'b1);
    check("rst_done", done_o, 1'b0);
    check("rst_error", error_o, 1'b0);
    check("rst_quo", quo_o, 16'd0);
    check("rst_rem", rem_o, 16'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);

    foreach (vecs[i]) begin
      do_op(vecs[i].s, vecs[i].a, vecs[i].b, edges, hold_ok);
      check($sformatf("vec%0d_lat", i), edges, vecs[i].lat);
      check($sformatf("vec%0d_quo", i), quo_o, vecs[i].q);
      check($sformatf("vec%0d_rem", i), rem_o, vecs[i].r);
      check($sformatf("vec%0d_err", i), error_o, vecs[i].e);
      check($sformatf("vec%0d_hold", i), hold_ok, 1'b1);
    end

    // Restart mid-operation: first op must never report done.
    nd = 0;
    @(negedge clk) sgn = 1'b0; a_in = 16'hFFFF; b_in = 16'd1; go = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (done_o) nd++; end
    @(negedge clk) go = 1'b0;
    @(posedge clk); #1;
    if (done_o) nd++;
    check("abort_busy", ready_o, 1'b0);
    @(negedge clk) a_in = 16'd9; b_in = 16'd4; go = 1'b1;
    edges = 0;
    do begin @(posedge clk); #1; edges++; end while (!done_o && edges < 40);
    check("abort_no_done", nd, 0);
    check("abort_lat", edges, 3);
    check("abort_quo", quo_o, 16'd2);
    check("abort_rem", rem_o, 16'd1);
    @(negedge clk) go = 1'b0;
    @(posedge clk);

    // go held high for 20 cycles -> one operation only.
    nd = 0;
    @(negedge clk) sgn = 1'b0; a_in = 16'd100; b_in = 16'd7; go = 1'b1;
    repeat (20) begin @(posedge clk); #1; if (done_o) nd++; end
    check("held_go_pulses", nd, 1);
    check("held_go_quo", quo_o, 16'd14);
    @(negedge clk) go = 1'b0;
    @(posedge clk);

    // Reset during RUN.
    @(negedge clk) a_in = 16'hFFFF; b_in = 16'd1; go = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1; go = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready", ready_o, 1'b1);
    check("midrst_quo", quo_o, 16'd0);
    check("midrst_rem", rem_o, 16'd0);
    check("midrst_error", error_o, 1'b0);
    check("midrst_done", done_o, 1'b0);
    @(negedge clk) rst = 1'b0;
    nd = 0;
    repeat (20) begin @(posedge clk); #1; if (done_o) nd++; end
    check("midrst_no_done", nd, 0);

    for (int n = 0; n < 150; n++) begin
      logic        rs;
      logic [15:0] ra, rb;
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'd0;
        1, 2:    rb = 16'($urandom_range(1, 15));
        3:       rb = 16'hFFFF;
        default: rb = 16'($urandom);
      endcase
      if (n % 25 == 0) ra = 16'h8000;
      ref_model(rs, ra, rb, eq, er, ee, el);
      do_op(rs, ra, rb, edges, hold_ok);
      check($sformatf("rnd%0d_lat s=%0b a=%0h b=%0h", n, rs, ra, rb), edges, el);
      check($sformatf("rnd%0d_quo s=%0b a=%0h b=%0h", n, rs, ra, rb), quo_o, eq);
      check($sformatf("rnd%0d_rem s=%0b a=%0h b=%0h", n, rs, ra, rb), rem_o, er);
      check($sformatf("rnd%0d_err", n), error_o, ee);
      check($sformatf("rnd%0d_hold", n), hold_ok, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
